// File: rtl/timer_alarm_pkg.sv
// timer_alarm_pkg: alarm state encodings and alarm CSR addresses shared by the timer
package timer_alarm_pkg;

    typedef enum logic [1:0] {
        TIMER_ALARM_IDLE  = 2'd0,
        TIMER_ALARM_ARMED = 2'd1,
        TIMER_ALARM_FIRED = 2'd2
    } alarm_state_e;

    localparam logic [7:0] ALARM_CMP_LOW  = 8'h20;
    localparam logic [7:0] ALARM_CMP_HIGH = 8'h24;
    localparam logic [7:0] ALARM_PERIOD   = 8'h28;
    localparam logic [7:0] ALARM_CTRL     = 8'h2C;
    localparam logic [7:0] ALARM_STATUS   = 8'h30;

endpackage

// File: rtl/timer_alarm.sv
// timer_alarm: compares the live timer against a 64-bit target and raises a level irq, one-shot or periodic
module timer_alarm
    import timer_alarm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 2 * DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  timer_value,
    input  logic [DATA_W-1:0] cfg_cmp_low,
    input  logic [DATA_W-1:0] cfg_cmp_high,
    input  logic [DATA_W-1:0] cfg_period,
    input  logic              cfg_periodic,
    input  logic              arm,
    input  logic              disarm,
    input  logic              irq_ack,
    output logic              irq,
    output logic              overrun,
    output logic [1:0]        alarm_state,
    output logic [DATA_W-1:0] fire_count
);

    alarm_state_e      state_q, state_d;
    logic [CNT_W-1:0]  target_q, target_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              periodic_q, periodic_d;
    logic              irq_q, irq_d;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] fire_count_q, fire_count_d;
    logic              hit;

    // State register; reset drops any pending irq
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= TIMER_ALARM_IDLE;
            target_q     <= '0;
            period_q     <= '0;
            periodic_q   <= 1'b0;
            irq_q        <= 1'b0;
            overrun_q    <= 1'b0;
            fire_count_q <= '0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            period_q     <= period_d;
            periodic_q   <= periodic_d;
            irq_q        <= irq_d;
            overrun_q    <= overrun_d;
            fire_count_q <= fire_count_d;
        end
    end

    // Next state: disarm beats arm beats hit bookkeeping; irq set wins over ack
    always_comb begin
        hit          = state_q == TIMER_ALARM_ARMED && timer_value >= target_q && !disarm;
        state_d      = state_q;
        target_d     = target_q;
        period_d     = period_q;
        periodic_d   = periodic_q;
        fire_count_d = fire_count_q;
        irq_d        = hit | (irq_q & ~irq_ack);
        overrun_d    = hit ? (~irq_ack & (overrun_q | irq_q)) : (overrun_q & ~irq_ack);
        if (disarm) begin
            state_d = TIMER_ALARM_IDLE;
        end else if (arm) begin
            state_d      = TIMER_ALARM_ARMED;
            target_d     = {cfg_cmp_high, cfg_cmp_low};
            period_d     = {{(CNT_W-DATA_W){1'b0}}, cfg_period};
            periodic_d   = cfg_periodic;
            fire_count_d = '0;
        end else if (hit) begin
            fire_count_d = fire_count_q + DATA_W'(1);
            if (periodic_q && period_q != '0) target_d = target_q + period_q;
            else state_d = TIMER_ALARM_FIRED;
        end
    end

    assign irq         = irq_q;
    assign overrun     = overrun_q;
    assign alarm_state = state_q;
    assign fire_count  = fire_count_q;

endmodule

// File: tb/tb_timer_alarm.sv
// tb_timer_alarm: directed scenarios plus random traffic against a behavioural alarm model
module tb_timer_alarm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] timer_value = '0;
    logic [31:0] cfg_cmp_low = '0, cfg_cmp_high = '0, cfg_period = '0;
    logic        cfg_periodic = 1'b0, arm = 1'b0, disarm = 1'b0, irq_ack = 1'b0;
    logic        irq, overrun;
    logic [1:0]  alarm_state;
    logic [31:0] fire_count;

    int tests = 0, fails = 0;
    logic [63:0] cnt = '0;

    logic [63:0] m_tgt = '0, m_per = '0;
    bit          m_mode = 0, m_irq = 0, m_ovr = 0;
    int          m_state = 0;
    logic [31:0] m_fc = '0;

    timer_alarm dut (
        .clk(clk), .rst(rst), .timer_value(timer_value),
        .cfg_cmp_low(cfg_cmp_low), .cfg_cmp_high(cfg_cmp_high), .cfg_period(cfg_period),
        .cfg_periodic(cfg_periodic), .arm(arm), .disarm(disarm), .irq_ack(irq_ack),
        .irq(irq), .overrun(overrun), .alarm_state(alarm_state), .fire_count(fire_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg(input logic [63:0] tgt, input logic [31:0] per, input bit mode);
        {cfg_cmp_high, cfg_cmp_low} = tgt;
        cfg_period = per;
        cfg_periodic = mode;
    endtask

    task automatic model_reset();
        m_tgt = '0; m_per = '0; m_mode = 0; m_irq = 0; m_ovr = 0; m_state = 0; m_fc = '0;
    endtask

    // One clock with the given pulses; the model advances by the alarm rules, then outputs are compared
    task automatic step(input bit a, input bit d, input bit k);
        bit h;
        @(negedge clk);
        arm = a; disarm = d; irq_ack = k; timer_value = cnt;
        h = (m_state == 1) && (cnt >= m_tgt) && !d;
        if (h) begin
            if (m_irq && !k) m_ovr = 1;
            if (k) m_ovr = 0;
            m_irq = 1;
        end else if (k) begin
            m_irq = 0;
            m_ovr = 0;
        end
        if (d) m_state = 0;
        else if (a) begin
            m_state = 1;
            m_tgt = {cfg_cmp_high, cfg_cmp_low};
            m_per = {32'd0, cfg_period};
            m_mode = cfg_periodic;
            m_fc = 0;
        end else if (h) begin
            m_fc = m_fc + 1;
            if (m_mode && m_per != 0) m_tgt = m_tgt + m_per;
            else m_state = 2;
        end
        @(posedge clk);
        #1;
        arm = 0; disarm = 0; irq_ack = 0;
        cnt = cnt + 1;
        check("irq", irq, m_irq);
        check("overrun", overrun, m_ovr);
        check("state", alarm_state, m_state);
        check("fire_count", fire_count, m_fc);
    endtask

    initial begin
        #3;
        check("rst_irq", irq, 0);
        check("rst_state", alarm_state, 0);
        check("rst_fc", fire_count, 0);
        @(negedge clk);
        rst = 0;

        // one-shot at 100
        cnt = 0;
        cfg(64'd100, 0, 0);
        step(1, 0, 0);
        for (int g = 0; g < 200 && m_state != 2; g++) step(0, 0, 0);
        check("t1_when", cnt, 101);
        check("t1_state", alarm_state, 2);
        check("t1_fc", fire_count, 1);
        repeat (3) step(0, 0, 0);
        check("t1_hold", irq, 1);
        step(0, 0, 1);
        check("t1_ack", irq, 0);

        // periodic 50/70/90 with acks
        cnt = 40;
        cfg(64'd50, 20, 1);
        step(1, 0, 0);
        while (cnt <= 100) step(0, 0, m_irq);
        check("t2_fc", fire_count, 3);
        check("t2_state", alarm_state, 1);
        check("t2_ovr", overrun, 0);
        check("t2_tgt", dut.target_q, 110);

        // overrun across two unacked hits
        cfg(cnt + 3, 5, 1);
        step(1, 0, 0);
        for (int g = 0; g < 50 && m_fc != 2; g++) step(0, 0, 0);
        check("t3_ovr", overrun, 1);
        step(0, 0, 1);
        check("t3_ack_irq", irq, 0);
        check("t3_ack_ovr", overrun, 0);
        step(0, 1, 0);

        // target in the past
        cnt = 1000;
        cfg(64'd10, 0, 0);
        step(1, 0, 0);
        check("t4_arm_irq", irq, 0);
        step(0, 0, 0);
        check("t4_irq", irq, 1);
        check("t4_state", alarm_state, 2);

        // simultaneous events
        cfg(64'd0, 0, 0);
        step(1, 0, 0);
        step(0, 0, 1);
        check("t5_hitack_irq", irq, 1);
        check("t5_hitack_ovr", overrun, 0);
        step(1, 1, 0);
        check("t5_armdis", alarm_state, 0);
        cfg(64'd0, 0, 1);
        step(1, 0, 0);
        step(0, 0, 0);
        check("t5_per0", alarm_state, 2);
        step(0, 0, 1);

        // wrap and async reset
        cnt = 64'hFFFF_FFFF_FFFF_FFF0;
        cfg(64'hFFFF_FFFF_FFFF_FFF6, 20, 1);
        step(1, 0, 0);
        for (int g = 0; g < 30 && m_fc != 1; g++) step(0, 0, 0);
        check("t6_wrap", dut.target_q, 10);
        check("t6_pre_irq", irq, 1);
        @(negedge clk);
        #2 rst = 1;
        #1;
        check("t6_rst_irq", irq, 0);
        check("t6_rst_state", alarm_state, 0);
        check("t6_rst_fc", fire_count, 0);
        check("t6_rst_tgt", dut.target_q, 0);
        model_reset();
        @(negedge clk);
        rst = 0;

        // random traffic
        cnt = 5000;
        for (int i = 0; i < 600; i++) begin
            bit a, d, k;
            a = ($urandom_range(0, 7) == 0);
            d = ($urandom_range(0, 29) == 0);
            k = ($urandom_range(0, 3) == 0);
            if (a) cfg(cnt + $urandom_range(0, 40) - 8, $urandom_range(0, 15), $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 19) == 0) cnt = cnt + $urandom_range(0, 30);
            step(a, d, k);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
